data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers each read/write request after a fixed
// LATENCY. Optional build macro DATAMEM_ERR_EN adds mem_err and out-of-range blocking.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
`ifdef DATAMEM_ERR_EN
    output logic        mem_err,
`endif
    output logic        mem_busy
);

    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    oor_q, oor_d;
    logic                    mem_we;
    logic                    req_oor;
    logic [31:0]             storage [DEPTH];

    // Byte-offset bits never select anything; the upper bits only matter for mem_err.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

`ifdef DATAMEM_ERR_EN
    assign req_oor = |(mem_addr >> (ADDR_WIDTH + 2));
`else
    assign req_oor = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    wr_d    = mem_write;
                    idx_d   = mem_addr[ADDR_WIDTH+1:2];
                    wdata_d = mem_wdata;
                    oor_d   = req_oor;
                    cnt_d   = LAT_M1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    // A write answers with the word it just stored.
                    if (oor_q) begin
                        rdata_d = 32'h0;
                    end else if (wr_q) begin
                        mem_we  = 1'b1;
                        rdata_d = wdata_q;
                    end else begin
                        rdata_d = storage[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Request latches and storage carry no reset; memory survives rst.
    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        oor_q   <= oor_d;
        if (mem_we) begin
            storage[idx_q] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_valid = (state_q == RESP);
    assign mem_busy  = (state_q != IDLE);
`ifdef DATAMEM_ERR_EN
    assign mem_err   = (state_q == RESP) && oor_q;
`endif

endmodule
